// File: rtl/adc_level_monitor_if.sv
// adc_level_monitor_if: CPU-facing config write and snapshot read bus of adc_level_monitor.
interface adc_level_monitor_if #(
    parameter int unsigned WIN_BITS = 16,
    parameter int unsigned CNT_BITS = 32
);
    logic                cfg_wr;
    logic [3:0]          cfg_addr;
    logic [WIN_BITS-1:0] cfg_data;
    logic [3:0]          rd_idx;
    logic [CNT_BITS-1:0] rd_data;

    // Requester side: issues config writes and selects a snapshot.
    modport master (
        output cfg_wr,
        output cfg_addr,
        output cfg_data,
        output rd_idx,
        input  rd_data
    );

    // Monitor side.
    modport slave (
        input  cfg_wr,
        input  cfg_addr,
        input  cfg_data,
        input  rd_idx,
        output rd_data
    );
endinterface

// File: rtl/adc_level_monitor.sv
// adc_level_monitor: per-window ADC magnitude level counts, overflow count,
// longest overflow run and run-length alarm, all in the adc_clk domain.
// Optional per-window peak magnitude tracking is enabled by ADC_LVL_PEAK_EN.
module adc_level_monitor #(
    parameter int unsigned ADC_BITS = 14,
    parameter int unsigned NLVL     = 4,
    parameter int unsigned WIN_BITS = 16,
    parameter int unsigned CNT_BITS = 32
) (
    input  logic                       adc_clk,
    input  logic                       adc_rst,
    input  logic signed [ADC_BITS-1:0] adc_data,
    input  logic                       adc_ovfl,
    adc_level_monitor_if.slave         bus,
    output logic                       win_done,
    output logic                       ovfl_flag,
    output logic                       run_alarm
);
    localparam int unsigned MAG_BITS = ADC_BITS - 1;
    localparam int unsigned CMP_BITS = (CNT_BITS > WIN_BITS) ? CNT_BITS : WIN_BITS;

    localparam logic [3:0] ADDR_WIN   = 4'd8;
    localparam logic [3:0] ADDR_MASK  = 4'd9;
    localparam logic [3:0] ADDR_ALARM = 4'd10;
    localparam logic [3:0] IDX_OVFL   = 4'd8;
    localparam logic [3:0] IDX_RUN    = 4'd9;

    // Configuration
    logic [MAG_BITS-1:0] thr_q [NLVL];
    logic [WIN_BITS-1:0] win_len_q;
    logic [WIN_BITS-1:0] ovfl_mask_q;
    logic [WIN_BITS-1:0] alarm_len_q;

    // Window accumulators and overflow run tracking
    logic [WIN_BITS-1:0] smp_cnt_q;
    logic [CNT_BITS-1:0] lvl_acc_q [NLVL];
    logic [CNT_BITS-1:0] ovfl_acc_q;
    logic [CNT_BITS-1:0] max_run_q;
    logic [CNT_BITS-1:0] run_q;
    logic                alarm_armed_q;

    // Snapshots seen by the CPU
    logic [CNT_BITS-1:0] lvl_snap_q [NLVL];
    logic [CNT_BITS-1:0] ovfl_snap_q;
    logic [CNT_BITS-1:0] max_run_snap_q;

    // Combinational helpers
    logic [ADC_BITS-1:0] neg_c;
    logic [MAG_BITS-1:0] mag_c;
    logic                cfg_hit_c;
    logic                win_end_c;
    logic                snap_c;
    logic [CNT_BITS-1:0] lvl_nxt_c [NLVL];
    logic [CNT_BITS-1:0] ovfl_nxt_c;
    logic [CNT_BITS-1:0] run_nxt_c;
    logic [CNT_BITS-1:0] max_run_nxt_c;
    logic                alarm_fire_c;

    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v,
                                                    input logic              en);
        return (en && (v != {CNT_BITS{1'b1}})) ? v + CNT_BITS'(1) : v;
    endfunction

    // Magnitude; the most negative code saturates instead of wrapping to zero.
    always_comb begin
        neg_c = (~adc_data) + ADC_BITS'(1);
        mag_c = adc_data[MAG_BITS-1:0];
        if (adc_data[ADC_BITS-1]) begin
            mag_c = neg_c[ADC_BITS-1] ? {MAG_BITS{1'b1}} : neg_c[MAG_BITS-1:0];
        end
    end

    // A write counts only when it targets a defined register.
    always_comb begin
        cfg_hit_c = 1'b0;
        if (bus.cfg_wr) begin
            if ((bus.cfg_addr == ADDR_WIN) || (bus.cfg_addr == ADDR_MASK) ||
                (bus.cfg_addr == ADDR_ALARM)) begin
                cfg_hit_c = 1'b1;
            end
            for (int i = 0; i < int'(NLVL); i++) begin
                if (bus.cfg_addr == 4'(i)) begin
                    cfg_hit_c = 1'b1;
                end
            end
        end
    end

    // Next accumulator values including the current sample, plus alarm decision.
    always_comb begin
        win_end_c = (smp_cnt_q == win_len_q);
        snap_c    = win_end_c && !cfg_hit_c;
        for (int i = 0; i < int'(NLVL); i++) begin
            lvl_nxt_c[i] = sat_inc(lvl_acc_q[i], mag_c >= thr_q[i]);
        end
        ovfl_nxt_c    = sat_inc(ovfl_acc_q, adc_ovfl);
        run_nxt_c     = adc_ovfl ? sat_inc(run_q, 1'b1) : '0;
        max_run_nxt_c = (run_nxt_c > max_run_q) ? run_nxt_c : max_run_q;
        alarm_fire_c  = alarm_armed_q && (alarm_len_q != '0) &&
                        (CMP_BITS'(run_q) == CMP_BITS'(alarm_len_q));
    end

    // Configuration registers.
    always_ff @(posedge adc_clk or posedge adc_rst) begin
        if (adc_rst) begin
            for (int i = 0; i < int'(NLVL); i++) begin
                thr_q[i] <= '1;
            end
            win_len_q   <= '1;
            ovfl_mask_q <= '1;
            alarm_len_q <= '0;
        end else if (bus.cfg_wr) begin
            for (int i = 0; i < int'(NLVL); i++) begin
                if (bus.cfg_addr == 4'(i)) begin
                    thr_q[i] <= MAG_BITS'(bus.cfg_data);
                end
            end
            case (bus.cfg_addr)
                ADDR_WIN:   win_len_q   <= bus.cfg_data;
                ADDR_MASK:  ovfl_mask_q <= bus.cfg_data;
                ADDR_ALARM: alarm_len_q <= bus.cfg_data;
                default: ;
            endcase
        end
    end

    // Sample counter and accumulators; cleared at window end or on a config restart.
    always_ff @(posedge adc_clk or posedge adc_rst) begin
        if (adc_rst) begin
            smp_cnt_q  <= '0;
            for (int i = 0; i < int'(NLVL); i++) begin
                lvl_acc_q[i] <= '0;
            end
            ovfl_acc_q <= '0;
            max_run_q  <= '0;
        end else if (cfg_hit_c || win_end_c) begin
            smp_cnt_q  <= '0;
            for (int i = 0; i < int'(NLVL); i++) begin
                lvl_acc_q[i] <= '0;
            end
            ovfl_acc_q <= '0;
            max_run_q  <= '0;
        end else begin
            smp_cnt_q  <= smp_cnt_q + WIN_BITS'(1);
            for (int i = 0; i < int'(NLVL); i++) begin
                lvl_acc_q[i] <= lvl_nxt_c[i];
            end
            ovfl_acc_q <= ovfl_nxt_c;
            max_run_q  <= max_run_nxt_c;
        end
    end

    // Overflow run length spans windows; the alarm re-arms once the run breaks.
    always_ff @(posedge adc_clk or posedge adc_rst) begin
        if (adc_rst) begin
            run_q         <= '0;
            alarm_armed_q <= 1'b1;
            run_alarm     <= 1'b0;
        end else begin
            run_q         <= run_nxt_c;
            alarm_armed_q <= (run_q == '0) ? 1'b1 : (alarm_armed_q && !alarm_fire_c);
            run_alarm     <= alarm_fire_c;
        end
    end

    // Snapshot at window end; a coincident config write suppresses it.
    always_ff @(posedge adc_clk or posedge adc_rst) begin
        if (adc_rst) begin
            for (int i = 0; i < int'(NLVL); i++) begin
                lvl_snap_q[i] <= '0;
            end
            ovfl_snap_q    <= '0;
            max_run_snap_q <= '0;
            win_done       <= 1'b0;
            ovfl_flag      <= 1'b0;
        end else begin
            win_done  <= snap_c;
            ovfl_flag <= snap_c &&
                         ((CMP_BITS'(ovfl_nxt_c) & CMP_BITS'(ovfl_mask_q)) != '0);
            if (snap_c) begin
                for (int i = 0; i < int'(NLVL); i++) begin
                    lvl_snap_q[i] <= lvl_nxt_c[i];
                end
                ovfl_snap_q    <= ovfl_nxt_c;
                max_run_snap_q <= max_run_nxt_c;
            end
        end
    end

`ifdef ADC_LVL_PEAK_EN
    localparam logic [3:0] IDX_PEAK = 4'd10;

    logic [MAG_BITS-1:0] peak_q;
    logic [MAG_BITS-1:0] peak_snap_q;
    logic [MAG_BITS-1:0] peak_nxt_c;

    // Peak magnitude including the current sample.
    always_comb begin
        peak_nxt_c = (mag_c > peak_q) ? mag_c : peak_q;
    end

    // Per-window peak, cleared together with the other accumulators.
    always_ff @(posedge adc_clk or posedge adc_rst) begin
        if (adc_rst) begin
            peak_q      <= '0;
            peak_snap_q <= '0;
        end else if (cfg_hit_c || win_end_c) begin
            peak_q <= '0;
            if (snap_c) begin
                peak_snap_q <= peak_nxt_c;
            end
        end else begin
            peak_q <= peak_nxt_c;
        end
    end
`endif

    // Snapshot read mux; undefined indices read as zero.
    always_comb begin
        bus.rd_data = '0;
        for (int i = 0; i < int'(NLVL); i++) begin
            if (bus.rd_idx == 4'(i)) begin
                bus.rd_data = lvl_snap_q[i];
            end
        end
        case (bus.rd_idx)
            IDX_OVFL: bus.rd_data = ovfl_snap_q;
            IDX_RUN:  bus.rd_data = max_run_snap_q;
`ifdef ADC_LVL_PEAK_EN
            IDX_PEAK: bus.rd_data = CNT_BITS'(peak_snap_q);
`endif
            default: ;
        endcase
    end
endmodule

// File: tb/tb_adc_level_monitor.sv
// tb_adc_level_monitor: directed and randomized checks of adc_level_monitor
// against a queue-based window model.
module tb_adc_level_monitor;
    localparam int unsigned ADC_BITS = 14;
    localparam int unsigned NLVL     = 4;
    localparam int unsigned WIN_BITS = 16;
    localparam int unsigned CNT_BITS = 32;
    localparam int          MAG_MAX  = (1 << (ADC_BITS - 1)) - 1;
    localparam longint      CNT_MAX  = (longint'(1) << CNT_BITS) - 1;

    logic                       adc_clk = 1'b0;
    logic                       adc_rst;
    logic signed [ADC_BITS-1:0] adc_data;
    logic                       adc_ovfl;
    logic                       win_done, ovfl_flag, run_alarm;
    logic                       win_done4, ovfl_flag4, run_alarm4;

    adc_level_monitor_if #(.WIN_BITS(WIN_BITS), .CNT_BITS(CNT_BITS)) bus ();
    adc_level_monitor_if #(.WIN_BITS(WIN_BITS), .CNT_BITS(4))        bus4 ();

    adc_level_monitor #(
        .ADC_BITS(ADC_BITS), .NLVL(NLVL), .WIN_BITS(WIN_BITS), .CNT_BITS(CNT_BITS)
    ) dut (
        .adc_clk(adc_clk), .adc_rst(adc_rst), .adc_data(adc_data), .adc_ovfl(adc_ovfl),
        .bus(bus.slave), .win_done(win_done), .ovfl_flag(ovfl_flag), .run_alarm(run_alarm)
    );

    adc_level_monitor #(
        .ADC_BITS(ADC_BITS), .NLVL(NLVL), .WIN_BITS(WIN_BITS), .CNT_BITS(4)
    ) dut4 (
        .adc_clk(adc_clk), .adc_rst(adc_rst), .adc_data(adc_data), .adc_ovfl(adc_ovfl),
        .bus(bus4.slave), .win_done(win_done4), .ovfl_flag(ovfl_flag4), .run_alarm(run_alarm4)
    );

    always #50 adc_clk = ~adc_clk;

    typedef struct {
        int     mag;
        bit     ov;
        longint run;
    } smp_t;

    smp_t   win_q[$];
    int     m_win_len, m_mask, m_alarm;
    int     m_thr [NLVL];
    longint m_run;
    bit     alarm_pend;
    longint s_lvl [NLVL];
    longint s_ovfl, s_max, s_peak;

    int checks = 0;
    int errors = 0;
    int alarm_seen = 0;
    int done_seen = 0;
    int flag_seen = 0;
    int done4_seen = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int mag_of(input int d);
        int m;
        m = (d < 0) ? -d : d;
        return (m > MAG_MAX) ? MAG_MAX : m;
    endfunction

    task automatic model_reset();
        m_win_len  = 65535;
        m_mask     = 65535;
        m_alarm    = 0;
        for (int i = 0; i < int'(NLVL); i++) begin
            m_thr[i] = MAG_MAX;
            s_lvl[i] = 0;
        end
        win_q.delete();
        m_run      = 0;
        alarm_pend = 1'b0;
        s_ovfl     = 0;
        s_max      = 0;
        s_peak     = 0;
    endtask

    // Summarise the collected window into the expected snapshot.
    task automatic close_window();
        for (int i = 0; i < int'(NLVL); i++) s_lvl[i] = 0;
        s_ovfl = 0;
        s_max  = 0;
        s_peak = 0;
        foreach (win_q[k]) begin
            for (int i = 0; i < int'(NLVL); i++) begin
                if (win_q[k].mag >= m_thr[i]) s_lvl[i]++;
            end
            if (win_q[k].ov) s_ovfl++;
            if (win_q[k].run > s_max) s_max = win_q[k].run;
            if (win_q[k].mag > s_peak) s_peak = win_q[k].mag;
        end
        for (int i = 0; i < int'(NLVL); i++) begin
            if (s_lvl[i] > CNT_MAX) s_lvl[i] = CNT_MAX;
        end
        if (s_ovfl > CNT_MAX) s_ovfl = CNT_MAX;
        win_q.delete();
    endtask

    function automatic longint exp_rd(input int idx);
        if (idx < int'(NLVL)) return s_lvl[idx];
        case (idx)
            8: return s_ovfl;
            9: return s_max;
`ifdef ADC_LVL_PEAK_EN
            10: return s_peak;
`endif
            default: return 0;
        endcase
    endfunction

    task automatic rd_chk(input string tag, input int idx, input longint exp);
        bus.rd_idx = 4'(idx);
        #1;
        chk(tag, 64'(bus.rd_data), exp);
    endtask

    task automatic check_snap();
        for (int i = 0; i < 16; i++) begin
            rd_chk($sformatf("rd_data[%0d]", i), i, exp_rd(i));
        end
    endtask

    // One sample (optionally with a config write), then check outputs after the edge.
    task automatic step(input int data, input bit ov, input bit wr = 1'b0,
                        input int addr = 0, input int wdata = 0);
        bit   valid_wr, e_done, e_flag, e_alarm;
        smp_t e;
        adc_data     = ADC_BITS'(data);
        adc_ovfl     = ov;
        bus.cfg_wr   = wr;
        bus.cfg_addr = 4'(addr);
        bus.cfg_data = WIN_BITS'(wdata);
        e_alarm  = alarm_pend;
        e_done   = 1'b0;
        e_flag   = 1'b0;
        m_run    = ov ? m_run + 1 : 0;
        valid_wr = wr && ((addr < int'(NLVL)) || addr == 8 || addr == 9 || addr == 10);
        if (valid_wr) begin
            if (addr < int'(NLVL)) m_thr[addr] = wdata & MAG_MAX;
            else if (addr == 8)    m_win_len = wdata;
            else if (addr == 9)    m_mask = wdata;
            else                   m_alarm = wdata;
            win_q.delete();
        end else begin
            e.mag = mag_of(data);
            e.ov  = ov;
            e.run = m_run;
            win_q.push_back(e);
            if (win_q.size() == m_win_len + 1) begin
                close_window();
                e_done = 1'b1;
                e_flag = (s_ovfl & longint'(m_mask)) != 0;
            end
        end
        alarm_pend = (m_alarm != 0) && (m_run == longint'(m_alarm));
        @(posedge adc_clk);
        #1;
        bus.cfg_wr = 1'b0;
        if (run_alarm === 1'b1) alarm_seen++;
        if (win_done === 1'b1)  done_seen++;
        if (ovfl_flag === 1'b1) flag_seen++;
        if (win_done4 === 1'b1) done4_seen++;
        chk("win_done", 64'(win_done), 64'(e_done));
        chk("ovfl_flag", 64'(ovfl_flag), 64'(e_flag));
        chk("run_alarm", 64'(run_alarm), 64'(e_alarm));
        if (e_done) check_snap();
    endtask

    initial begin
        int  d;
        int  a;
        int  w;
        bit  ov_state;
        adc_rst       = 1'b1;
        adc_data      = '0;
        adc_ovfl      = 1'b0;
        bus.cfg_wr    = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_data  = '0;
        bus.rd_idx    = '0;
        bus4.cfg_wr   = 1'b0;
        bus4.cfg_addr = '0;
        bus4.cfg_data = '0;
        bus4.rd_idx   = '0;
        ov_state      = 1'b0;
        model_reset();
        repeat (2) @(posedge adc_clk);
        #1;
        chk("rst_win_done", 64'(win_done), 0);
        chk("rst_ovfl_flag", 64'(ovfl_flag), 0);
        chk("rst_run_alarm", 64'(run_alarm), 0);
        check_snap();
        adc_rst = 1'b0;

        // Window 8 samples, thresholds 100..400, constant 250.
        step(250, 0, 1, 8, 7);
        step(250, 0, 1, 0, 100);
        step(250, 0, 1, 1, 200);
        step(250, 0, 1, 2, 300);
        step(250, 0, 1, 3, 400);
        done_seen = 0;
        for (int k = 0; k < 16; k++) step(250, 0);
        chk("basic_done_count", 64'(done_seen), 2);
        rd_chk("basic_lvl0", 0, 8);
        rd_chk("basic_lvl1", 1, 8);
        rd_chk("basic_lvl2", 2, 0);
        rd_chk("basic_lvl3", 3, 0);

        // Most negative code saturates to full-scale magnitude.
        step(0, 0, 1, 8, 3);
        for (int k = 0; k < 4; k++) step(-8192, 0);
        for (int i = 0; i < 4; i++) rd_chk($sformatf("neg_lvl%0d", i), i, 4);
`ifdef ADC_LVL_PEAK_EN
        rd_chk("neg_peak", 10, 8191);
`else
        rd_chk("neg_peak", 10, 0);
`endif

        // Overflow burst of 5 with mask 4 then mask 2, alarm length 3.
        step(0, 0, 1, 8, 15);
        step(0, 0, 1, 9, 4);
        step(0, 0, 1, 10, 3);
        alarm_seen = 0;
        flag_seen  = 0;
        for (int k = 0; k < 16; k++) step(0, k < 5);
        chk("ovfl_alarm_once", 64'(alarm_seen), 1);
        chk("ovfl_flag_m4", 64'(flag_seen), 1);
        rd_chk("ovfl_count", 8, 5);
        rd_chk("ovfl_max_run", 9, 5);
        step(0, 0, 1, 9, 2);
        alarm_seen = 0;
        flag_seen  = 0;
        for (int k = 0; k < 16; k++) step(0, k < 5);
        chk("ovfl_alarm_once_m2", 64'(alarm_seen), 1);
        chk("ovfl_flag_m2", 64'(flag_seen), 0);

        // Config write coinciding with the final sample of a window.
        step(0, 0, 1, 8, 7);
        for (int k = 0; k < 7; k++) step(300 + k * 10, 0);
        done_seen = 0;
        step(500, 0, 1, 0, 50);
        chk("collide_no_done", 64'(done_seen), 0);
        check_snap();
        for (int k = 0; k < 7; k++) step(40 + k * 3, 0);
        chk("collide_still_none", 64'(done_seen), 0);
        step(60, 0);
        chk("collide_done_after", 64'(done_seen), 1);

        // Randomized traffic against the model.
        step(0, 0, 1, 8, 5);
        for (int n = 0; n < 2500; n++) begin
            d = int'($urandom_range(0, 16383)) - 8192;
            if ($urandom_range(0, 15) == 0) d = -8192;
            if ($urandom_range(0, 3) == 0) ov_state = ~ov_state;
            if ($urandom_range(0, 39) == 0) begin
                a = int'($urandom_range(0, 15));
                if (a == 8)       w = int'($urandom_range(0, 20));
                else if (a == 10) w = int'($urandom_range(0, 6));
                else              w = int'($urandom_range(0, 65535));
                step(d, ov_state, 1, a, w);
            end else begin
                step(d, ov_state);
            end
        end
        step(0, 0);

        // Narrow counters saturate instead of wrapping.
        bus4.cfg_wr   = 1'b1;
        bus4.cfg_addr = 4'd8;
        bus4.cfg_data = 16'd31;
        step(0, 0);
        bus4.cfg_addr = 4'd0;
        bus4.cfg_data = 16'd100;
        step(0, 0);
        bus4.cfg_wr = 1'b0;
        done4_seen  = 0;
        for (int k = 0; k < 32; k++) step(5000, 0);
        chk("sat_done4", 64'(done4_seen), 1);
        chk("sat_flag4", 64'(ovfl_flag4), 0);
        chk("sat_alarm4", 64'(run_alarm4), 0);
        bus4.rd_idx = 4'd0;
        #1;
        chk("sat_lvl0", 64'(bus4.rd_data), 15);
        bus4.rd_idx = 4'd1;
        #1;
        chk("sat_lvl1", 64'(bus4.rd_data), 0);

        // Asynchronous reset mid-window with live snapshots and an alarm pulse.
        step(0, 0, 1, 8, 3);
        step(0, 0, 1, 10, 2);
        for (int k = 0; k < 4; k++) step(8191, 0);
        rd_chk("pre_rst_lvl0", 0, 4);
        step(0, 1);
        step(0, 1);
        step(0, 1);
        chk("pre_rst_alarm", 64'(run_alarm), 1);
        adc_rst = 1'b1;
        #2;
        chk("async_win_done", 64'(win_done), 0);
        chk("async_ovfl_flag", 64'(ovfl_flag), 0);
        chk("async_run_alarm", 64'(run_alarm), 0);
        model_reset();
        check_snap();
        @(posedge adc_clk);
        #1;
        adc_rst = 1'b0;

        // Reset thresholds (full scale) and mask (all ones) are back in effect.
        step(0, 0, 1, 8, 3);
        step(8191, 1);
        step(8190, 0);
        step(-8192, 0);
        step(0, 0);
        rd_chk("post_rst_lvl0", 0, 2);
        rd_chk("post_rst_ovfl", 8, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
